freq_autorange: RTL
===================

Name: freq_autorange

Overview:
- Post-processing stage between the gated decimal frequency counter and the 4-digit seven-segment controller.
- Captures the full BCD count on the measurement-lock strobe and finds the most significant non-zero digit with a sequential scan.
- Selects a 4-digit display window, a decimal-point position and a range code (Hz/kHz/MHz), then presents a registered result with a one-cycle valid strobe.
- Replaces the fixed top-16-bit truncation with auto-ranging.

Parameters:
- DIG_IN, 8, number of BCD input digits. Legal values 5..10. Display width is fixed at 4 digits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bcd_i  input  4*DIG_IN  BCD count; digit k occupies bits [4k+3:4k], k=0 is units (Hz)
- bcd_valid_i  input  1  one-cycle strobe: bcd_i is stable and must be captured
- hold_i  input  1  freeze: while high, bcd_valid_i is ignored
- data_o  output  16  4 BCD digits for the segment controller; position 0 = rightmost
- dp_o  output  4  one-hot decimal point per display position, or all zero
- range_o  output  2  0=Hz, 1=kHz, 2=MHz (3 unused)
- blank_o  output  4  per-position blank request (leading-zero suppression)
- valid_o  output  1  one-cycle pulse when the outputs are updated
- busy_o  output  1  high while a capture is being processed

Behaviour:
- Reset (rst_n low, asynchronous): data_o=0, dp_o=0, range_o=0, blank_o=0, valid_o=0, busy_o=0, FSM=IDLE, shadow register=0.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - On an edge with bcd_valid_i=1 and hold_i=0: copy bcd_i into the shadow register, set idx=DIG_IN-1, go to SCAN.
  - Otherwise remain in IDLE.
- SCAN, one digit per clock:
  - If shadow digit[idx]!=0 or idx==3: msd=idx, go to EMIT.
  - Else idx=idx-1.
  - Any non-BCD digit (>9) counts as non-zero. There is no error flag.
- EMIT: register the outputs, pulse valid_o for exactly the following cycle, return to IDLE.
- Window:
  - l = msd-3 (so l=0 when msd=3).
  - data_o = shadow digits [l+3:l], truncated, with no rounding.
- Range:
  - r = 0 if msd<=3.
  - Otherwise r = ceil((msd-3)/3).
  - range_o = r.
- Decimal point:
  - p = 3r - l.
  - dp_o = one-hot at position p when p is 1..3.
  - dp_o = 0 when p = 0 (integer display, no trailing point).
- Timing:
  - busy_o is high in SCAN and EMIT.
  - Latency from the capture edge to the output-update edge = (DIG_IN-1-msd)+2 edges, so 2..DIG_IN-2 edges.
  - Outputs hold their values between updates.
- Boundary conditions:
  - bcd_valid_i while busy_o=1 (including the EMIT cycle): dropped; no queuing.
  - bcd_valid_i and hold_i high on the same edge: ignored.
  - hold_i rising mid-scan: has no effect; the current scan completes and emits.
  - All-zero input: msd=3, data_o=0x0000, range 0, dp_o=0.
  - Reset mid-scan: immediate return to the reset values; no valid_o pulse.

Optional Feature:
- FREQ_AUTORANGE_BLANK_EN defined: in EMIT, blank_o[j]=1 for each position j in 3..1 whose digit is 0 and every higher position is also 0, but only when r=0. Position 0 is never blanked. blank_o is 0 for r>=1.
- Macro undefined: blank_o is constant 0, and the blanking logic is not compiled.

Test Plan:
- DIG_IN=8, bcd_i=0x27000000, strobe -> after 2 edges: data_o=0x2700, dp_o=4'b0100, range_o=2, valid_o pulses once; busy_o high for exactly 2 cycles.
- bcd_i=0x00012345 -> after 5 edges: data_o=0x1234, dp_o=4'b0100, range_o=1. bcd_i=0x00123456 -> data_o=0x1234, dp_o=4'b0010, range_o=1.
- bcd_i=0x00000007 -> after 6 edges: data_o=0x0007, dp_o=0, range_o=0; blank_o=4'b1110 with the macro defined, 4'b0000 without. bcd_i=0 -> data_o=0, same blank_o.
- Strobe with 0x00001000, then a second strobe with 0x99999999 two cycles later -> second strobe dropped; output data_o=0x1000, range_o=0; exactly one valid_o pulse.
- hold_i=1 with strobe 0x00005000 -> no busy_o, no valid_o, outputs unchanged; release hold_i and strobe -> normal update.
- Assert rst_n low during SCAN for 0x00000001 -> all outputs 0 immediately; no valid_o after release; the next strobe processes normally.

Source files
------------

// File: rtl/freq_autorange.sv
// freq_autorange: auto-ranging stage between the gated BCD frequency counter
// and the 4-digit seven-segment controller.
// A lock strobe captures the whole BCD count into a shadow register. The most
// significant non-zero digit is then found by scanning down one digit per
// clock. From that digit the block derives a 4-digit display window, a
// decimal-point position and a Hz/kHz/MHz range code, and presents them as a
// registered result with a one-cycle valid strobe.
// Optional feature: define FREQ_AUTORANGE_BLANK_EN to enable leading-zero
// blanking on Hz-range results. When the macro is undefined, blank_o is tied
// to zero.
module freq_autorange #(
    parameter int DIG_IN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIG_IN-1:0] bcd_i,
    input  logic                bcd_valid_i,
    input  logic                hold_i,
    output logic [15:0]         data_o,
    output logic [3:0]          dp_o,
    output logic [1:0]          range_o,
    output logic [3:0]          blank_o,
    output logic                valid_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    state_t              state;
    logic [4*DIG_IN-1:0] shadow;
    logic [3:0]          idx;
    logic [3:0]          msd;

    logic [3:0]          cur_digit;
    logic [3:0]          win_lo;
    logic [15:0]         window;
    logic [1:0]          range_next;
    logic [3:0]          range_x3;
    logic [3:0]          dp_pos;
    logic [3:0]          dp_next;

    // Select the shadow digit that the scan is currently inspecting.
    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIG_IN; k++) begin
            if (idx == 4'(k)) begin
                cur_digit = shadow[4*k +: 4];
            end
        end
    end

    // Cut the 4-digit window whose top digit is the msd; the lower digits are truncated, not rounded.
    always_comb begin
        win_lo = msd - 4'd3;
        window = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < DIG_IN; k++) begin
                if (win_lo + 4'(j) == 4'(k)) begin
                    window[4*j +: 4] = shadow[4*k +: 4];
                end
            end
        end
    end

    // Range code is ceil((msd-3)/3); the decimal point falls 3r-l digits from the right.
    always_comb begin
        if (msd <= 4'd3) begin
            range_next = 2'd0;
        end else if (msd <= 4'd6) begin
            range_next = 2'd1;
        end else if (msd <= 4'd9) begin
            range_next = 2'd2;
        end else begin
            range_next = 2'd3;
        end
        range_x3 = {2'b00, range_next} + {1'b0, range_next, 1'b0};
        dp_pos   = range_x3 - win_lo;
        case (dp_pos)
            4'd1:    dp_next = 4'b0010;
            4'd2:    dp_next = 4'b0100;
            4'd3:    dp_next = 4'b1000;
            default: dp_next = 4'b0000;
        endcase
    end

`ifdef FREQ_AUTORANGE_BLANK_EN
    logic [3:0] blank_next;

    // Blank leading zeros of a Hz-range result; the units position always stays lit.
    always_comb begin
        blank_next    = 4'b0000;
        blank_next[3] = (window[15:12] == 4'd0);
        blank_next[2] = blank_next[3] && (window[11:8] == 4'd0);
        blank_next[1] = blank_next[2] && (window[7:4] == 4'd0);
        if (range_next != 2'd0) begin
            blank_next = 4'b0000;
        end
    end
`endif

    // Capture / scan / emit sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shadow  <= '0;
            idx     <= 4'd0;
            msd     <= 4'd3;
            data_o  <= 16'h0000;
            dp_o    <= 4'b0000;
            range_o <= 2'd0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
`ifdef FREQ_AUTORANGE_BLANK_EN
            blank_o <= 4'b0000;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bcd_valid_i && !hold_i) begin
                        shadow <= bcd_i;
                        idx    <= 4'(DIG_IN - 1);
                        busy_o <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_digit != 4'd0 || idx == 4'd3) begin
                        msd   <= idx;
                        state <= EMIT;
                    end else begin
                        idx <= idx - 4'd1;
                    end
                end
                EMIT: begin
                    data_o  <= window;
                    dp_o    <= dp_next;
                    range_o <= range_next;
`ifdef FREQ_AUTORANGE_BLANK_EN
                    blank_o <= blank_next;
`endif
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifndef FREQ_AUTORANGE_BLANK_EN
    assign blank_o = 4'b0000;
`endif

endmodule
